// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU followed by non-overlapping 2x2 max-pool on an FP16 raster stream.
// One element in per handshake; one pooled element out per 2x2 window, with a frame-end marker.
module relu_maxpool2x2 #(
    parameter int unsigned WIDTH  = 28,
    parameter int unsigned HEIGHT = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        m_last
);
    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [14:0]   hmax;
    logic [14:0]   line_buf [HALF];

    logic          accept;
    logic          col_last;
    logic          row_last;
    logic [14:0]   x;
    logic [14:0]   pair;
    logic [14:0]   buf_rd;
    logic [14:0]   result;
    logic [BW-1:0] buf_idx;

    assign s_ready  = !m_valid || m_ready;
    assign accept   = s_valid && s_ready;
    assign col_last = (col == CW'(WIDTH - 1));
    assign row_last = (row == RW'(HEIGHT - 1));

    // After ReLU every value is non-negative and finite, so magnitude bits compare as unsigned.
    // Ties keep the earlier operand; the bit patterns are identical anyway.
    always_comb begin
        x       = (s_data[15] || (s_data[14:10] == 5'h1F)) ? 15'h0000 : s_data[14:0];
        pair    = (x > hmax) ? x : hmax;
        buf_idx = BW'(col >> 1);
        buf_rd  = line_buf[buf_idx];
        result  = (pair > buf_rd) ? pair : buf_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            hmax <= '0;
        end else if (accept) begin
            if (!col[0]) begin
                hmax <= x;
            end
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Written on every even row before the odd row reads it, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) begin
            line_buf[buf_idx] <= pair;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 16'h0000;
            m_last  <= 1'b0;
        end else if (accept && col[0] && row[0]) begin
            m_valid <= 1'b1;
            m_data  <= {1'b0, result};
            m_last  <= row_last && col_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed bench for relu_maxpool2x2: three instances (2x2, 4x4, 28x28) share clock and reset.
module tb_relu_maxpool2x2;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       s_valid = '0;
    logic [2:0][15:0] s_data  = '0;
    logic [2:0]       hold    = '0;
    logic [2:0]       rnd     = '0;
    logic [2:0]       rbit    = '0;
    wire  [2:0]       s_ready;
    wire  [2:0]       m_valid;
    wire  [2:0]       m_last;
    wire  [2:0]       m_ready;
    wire  [2:0][15:0] m_data;

    assign m_ready = ~hold & (~rnd | rbit);

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 2 : (g == 1) ? 4 : 28;
        relu_maxpool2x2 #(.WIDTH(W), .HEIGHT(W)) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .s_valid(s_valid[g]),
            .s_ready(s_ready[g]),
            .s_data (s_data[g]),
            .m_valid(m_valid[g]),
            .m_ready(m_ready[g]),
            .m_data (m_data[g]),
            .m_last (m_last[g])
        );
    end

    always @(posedge clk) begin
        #1;
        rbit = 3'($urandom);
    end

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] q2[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid[0] && m_ready[0]) q0.push_back({m_last[0], m_data[0]});
            if (m_valid[1] && m_ready[1]) q1.push_back({m_last[1], m_data[1]});
            if (m_valid[2] && m_ready[2]) q2.push_back({m_last[2], m_data[2]});
        end
    end

    int n_total = 0;
    int n_bad   = 0;
    int w;
    int stalls;
    logic [15:0] vals [64];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int g);
        case (g)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [16:0] qget(input int g, input int k);
        if (k >= qsize(g)) return 17'h1FFFF;
        case (g)
            0:       return q0[k];
            1:       return q1[k];
            default: return q2[k];
        endcase
    endfunction

    task automatic qclear();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    function automatic logic [15:0] fp16_of(input int v);
        int e = 0;
        int mant;
        if (v == 0) return 16'h0000;
        for (int b = 0; b < 11; b++) if (v >= (1 << b)) e = b;
        mant = (v << (10 - e)) & 'h3FF;
        return {1'b0, 5'(e + 15), 10'(mant)};
    endfunction

    function automatic logic [15:0] relu_m(input logic [15:0] v);
        return (v[15] || v[14:10] == 5'h1F) ? 16'h0000 : v;
    endfunction

    function automatic logic [15:0] win_max(input int base, input int pr, input int pc);
        logic [15:0] m = 16'h0000;
        logic [15:0] v;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                v = relu_m(vals[base + (2 * pr + dr) * 4 + 2 * pc + dc]);
                if (v > m) m = v;
            end
        return m;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the element has been accepted.
    task automatic send(input int g, input logic [15:0] d, input bit gaps, output int waits);
        if (gaps)
            for (int i = 0; i < 3 && $urandom_range(1, 0) == 0; i++) begin
                @(posedge clk);
                #1;
            end
        s_valid[g] = 1'b1;
        s_data[g]  = d;
        waits      = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!s_ready[g] && waits < 300);
        if (!s_ready[g]) check_eq("send_timeout", 32'(s_ready[g]), 1);
        @(posedge clk);
        #1;
        s_valid[g] = 1'b0;
    endtask

    task automatic wait_q(input int g, input int n, input string tag);
        for (int i = 0; i < 400 && qsize(g) < n; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        check_eq(tag, qsize(g), n);
    endtask

    task automatic run_full(input bit with_hold);
        logic [16:0] got;
        int v;
        qclear();
        stalls = 0;
        for (int i = 0; i < 784; i++) begin
            send(2, fp16_of(i), 1'b0, w);
            stalls += w - 1;
            if (with_hold && i == 29) begin
                hold[2]    = 1'b1;
                s_valid[2] = 1'b1;
                s_data[2]  = fp16_of(30);
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check_eq("hold_sready", 32'(s_ready[2]), 0);
                    check_eq("hold_mvalid", 32'(m_valid[2]), 1);
                    check_eq("hold_mdata", 32'(m_data[2]), 32'(fp16_of(29)));
                    @(posedge clk);
                    #1;
                end
                hold[2] = 1'b0;
            end
        end
        if (!with_hold) check_eq("full_stalls", stalls, 0);
        wait_q(2, 196, with_hold ? "bp_count" : "full_count");
        for (int k = 0; k < 196; k++) begin
            got = qget(2, k);
            v   = (2 * (k / 14) + 1) * 28 + 2 * (k % 14) + 1;
            check_eq(with_hold ? "bp_data" : "full_data", 32'(got[15:0]), 32'(fp16_of(v)));
            check_eq(with_hold ? "bp_last" : "full_last", 32'(got[16]), 32'(k == 195));
        end
    endtask

    task automatic check_4x4(input int base, input int nframes, input string tag);
        logic [16:0] got;
        for (int k = 0; k < 4 * nframes; k++) begin
            got = qget(1, k);
            check_eq({tag, "_data"}, 32'(got[15:0]),
                     32'(win_max(base + (k / 4) * 16, (k % 4) / 2, k % 2)));
            check_eq({tag, "_last"}, 32'(got[16]), 32'(k % 4 == 3));
        end
    endtask

    initial begin
        logic [16:0] got;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check_eq("rst_mvalid", 32'(m_valid[g]), 0);
            check_eq("rst_mdata", 32'(m_data[g]), 0);
            check_eq("rst_mlast", 32'(m_last[g]), 0);
            check_eq("rst_sready", 32'(s_ready[g]), 1);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2x2 basic: ReLU of mixed signs, single output one cycle after the 4th accept
        send(0, 16'hBC00, 1'b0, w);
        send(0, 16'h3800, 1'b0, w);
        send(0, 16'h4000, 1'b0, w);
        check_eq("basic_pre_valid", 32'(m_valid[0]), 0);
        send(0, 16'hC200, 1'b0, w);
        check_eq("basic_valid", 32'(m_valid[0]), 1);
        check_eq("basic_mdata", 32'(m_data[0]), 32'h4000);
        check_eq("basic_mlast", 32'(m_last[0]), 1);
        wait_q(0, 1, "basic_count");
        got = qget(0, 0);
        check_eq("basic_q", 32'(got), 32'h14000);

        // 2x2 all-negative / -0 / -Inf / NaN window
        qclear();
        send(0, 16'hBC00, 1'b0, w);
        send(0, 16'h8000, 1'b0, w);
        send(0, 16'hFC00, 1'b0, w);
        send(0, 16'h7E00, 1'b0, w);
        wait_q(0, 1, "neg_count");
        got = qget(0, 0);
        check_eq("neg_q", 32'(got), 32'h10000);

        run_full(1'b0);
        run_full(1'b1);

        // Three back-to-back 4x4 frames with random input gaps and random m_ready
        for (int i = 0; i < 64; i++) vals[i] = 16'($urandom);
        vals[0]  = 16'h7C00;
        vals[5]  = 16'h8000;
        vals[10] = 16'hFE00;
        vals[17] = 16'h7BFF;
        qclear();
        rnd[1] = 1'b1;
        for (int i = 0; i < 48; i++) send(1, vals[i], 1'b1, w);
        wait_q(1, 12, "rnd_count");
        rnd[1] = 1'b0;
        check_4x4(0, 3, "rnd");

        // Mid-frame async reset: pending output on the 2x2 instance, 13 inputs into the 4x4
        hold[0] = 1'b1;
        send(0, 16'h3C00, 1'b0, w);
        send(0, 16'h4000, 1'b0, w);
        send(0, 16'h3800, 1'b0, w);
        send(0, 16'h0000, 1'b0, w);
        for (int i = 0; i < 13; i++) send(1, vals[i], 1'b0, w);
        check_eq("pre_rst_pending", 32'(m_valid[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_mvalid0", 32'(m_valid[0]), 0);
        check_eq("arst_mdata0", 32'(m_data[0]), 0);
        check_eq("arst_sready0", 32'(s_ready[0]), 1);
        check_eq("arst_mvalid1", 32'(m_valid[1]), 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        hold[0] = 1'b0;
        qclear();
        for (int i = 48; i < 64; i++) send(1, vals[i], 1'b0, w);
        wait_q(1, 4, "rst_count");
        check_4x4(48, 1, "rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/relu_maxpool2x2.md
# relu_maxpool2x2

Streaming ReLU plus 2×2 max-pool stage that sits directly downstream of the bias-add stage in the CNN datapath. It accepts the bias-added FP16 feature map one element per handshake in raster order, clamps negatives to zero, and emits the maximum of each non-overlapping 2×2 window. Output is a (WIDTH/2)×(HEIGHT/2) FP16 map, also in raster order, with a last-element marker.

## Interface
- WIDTH, 28, elements per input row; must be even, ≥2.
- HEIGHT, 28, input rows per frame; must be even, ≥2.
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- s_valid  input  1  input element valid.
- s_ready  output  1  block can accept an element this cycle.
- s_data  input  16  FP16 element: bit 15 sign, 14:10 exponent, 9:0 mantissa.
- m_valid  output  1  pooled output valid.
- m_ready  input  1  downstream accepts output this cycle.
- m_data  output  16  pooled FP16 result.
- m_last  output  1  high with the final pooled element of a frame.

## Operation
- Transfer rules: input accepted when s_valid && s_ready; output consumed when m_valid && m_ready.
- ReLU on every accepted element: if bit 15 = 1, or exponent = 5'h1F (Inf/NaN of either sign), value becomes 16'h0000; otherwise unchanged. -0 (16'h8000) becomes 16'h0000.
- After ReLU, all values are non-negative finite FP16, so max is an unsigned compare of bits 14:0. On equal values the earlier one is kept; bit patterns are equal in that case.
- Counters:
  - col (0..WIDTH-1) advances on each accepted input.
  - row (0..HEIGHT-1) advances when col wraps.
  - Both wrap to 0 after the last element of a frame. There is no gap between frames.
- Horizontal register hmax:
  - Even col: hmax <= relu(x).
  - Odd col: pair = max(hmax, relu(x)).
- Line buffer: WIDTH/2 entries × 15 bits, indexed col/2.
  - Even row, odd col: buf[col/2] <= pair. No output.
  - Odd row, odd col: result = max(buf[col/2], pair). result is loaded into the output register with m_valid=1. m_last=1 iff row=HEIGHT-1 and col=WIDTH-1.
- Output register is single-entry; m_data bit 15 is always 0.
- s_ready = !m_valid || m_ready. The register is refilled in the same cycle it drains, so there is no bubble at full throughput.
- Line buffer contents are don't-care after reset. Every entry is written on the even row before it is read on the odd row.

## Timing
- Reset (async assert, sync release by the system): m_valid=0, m_data=16'h0000, m_last=0, s_ready=1, col=0, row=0, hmax=0.
- Latency: m_valid rises on the clock edge that accepts the 4th element of a window (odd row, odd col). The result is visible in the following cycle.
- Throughput: one input per cycle while m_ready stays high. Output rate is one per 4 inputs on average, bursting one per 2 inputs during odd rows.
- Backpressure: if m_valid=1 and m_ready=0, then s_ready=0. No input is accepted, no counter moves, and m_data/m_last hold stable until taken.
- s_valid=0 holds all state. Gaps in the input stream are allowed anywhere, including mid-window and mid-row.
- Frame wrap:
  - After the element at (HEIGHT-1, WIDTH-1) is accepted, col and row return to 0 on that same edge.
  - The next frame's first element may be accepted in the next cycle, even while m_last is still pending, provided s_ready=1.
- Reset mid-frame: all partial window and frame progress is discarded and any pending output is dropped. The next accepted element is treated as (0,0).

## Test plan
- ReLU/pool basic (WIDTH=HEIGHT=2):
  - Input 16'hBC00 (-1.0), 16'h3800 (0.5), 16'h4000 (2.0), 16'hC200 (-3.0).
  - Expect exactly one output: 16'h4000 with m_last=1, one cycle after the 4th accept.
- All-negative window:
  - Input 16'hBC00, 16'h8000, 16'hFC00 (-Inf), 16'h7E00 (NaN).
  - Expect 16'h0000, m_last=1.
- Full 28×28 frame, element value = (r*28+c) in FP16 integer encoding, m_ready=1:
  - Expect 196 outputs. Output k at (pr,pc) equals FP16 of ((2pr+1)*28+2pc+1).
  - m_last is asserted only on output 196; s_ready stays 1 throughout.
- Backpressure: in the full-frame test, hold m_ready=0 for 10 cycles at the first output.
  - Expect s_ready=0 and m_data stable during the hold, no lost or duplicated data, and an identical final sequence.
- Random s_valid and m_ready (50% each) over 3 back-to-back 4×4 frames.
  - Expect output compared against a software model; 4 outputs per frame; m_last on every 4th.
- Async reset asserted after 13 inputs of a 4×4 frame, then a new clean frame.
  - Expect m_valid=0 immediately, and the new frame produces exactly 4 correct outputs.
